// File: rtl/pong_pkg.sv
// Shared pong definitions: screen height and the paddle AI state encoding.
package pong_pkg;

    localparam int Y_RESOLUTION = 600;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REACT    = 2'd1,
        TRACK    = 2'd2,
        RECENTER = 2'd3
    } ai_state_t;

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), reset to a nonzero seed.
module lfsr16 (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    output logic [15:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= 16'hACE1;
        end else if (en) begin
            q <= {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
        end
    end

endmodule

// File: rtl/paddle_ai.sv
// Computer paddle controller: waits a reaction delay, tracks the ball, recentres.
// Optional aim jitter is enabled by defining PADDLE_AI_JITTER_EN.
module paddle_ai
    import pong_pkg::*;
#(
    parameter int REACTION_TICKS = 1000,
    parameter int DEADBAND       = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               game_on,
    input  logic               ball_toward,
    input  logic signed [31:0] ball_y,
    input  logic signed [31:0] paddle_position,
    output logic               up,
    output logic               down,
    output logic [1:0]         ai_state
);

    localparam int CW = (REACTION_TICKS > 1) ? $clog2(REACTION_TICKS) : 1;
    localparam logic [CW-1:0]      CNT_LAST = CW'(REACTION_TICKS - 1);
    localparam logic signed [32:0] DB_POS   = 33'(DEADBAND);
    localparam logic signed [32:0] DB_NEG   = -33'(DEADBAND);
    localparam logic signed [32:0] Y_MAX    = 33'(Y_RESOLUTION);
    localparam logic signed [32:0] Y_MID    = 33'(Y_RESOLUTION / 2);

    ai_state_t          state, next_state;
    logic [CW-1:0]      cnt, cnt_next;
    logic signed [32:0] jitter_off;
    logic signed [32:0] aim, target, err;
    logic               want_up, want_down;

    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        if (!game_on) begin
            next_state = IDLE;
            cnt_next   = '0;
        end else begin
            case (state)
                IDLE: begin
                    next_state = ball_toward ? REACT : RECENTER;
                    cnt_next   = '0;
                end
                REACT: begin
                    if (cnt == CNT_LAST) begin
                        next_state = TRACK;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + CW'(1);
                    end
                end
                TRACK: begin
                    if (!ball_toward) next_state = RECENTER;
                end
                RECENTER: begin
                    if (ball_toward) begin
                        next_state = REACT;
                        cnt_next   = '0;
                    end
                end
                default: begin
                    next_state = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

`ifdef PADDLE_AI_JITTER_EN
    logic [15:0]        lfsr_q;
    logic signed [32:0] off_q;

    lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .q     (lfsr_q)
    );

    // The offset is captured as the paddle starts tracking and held until the next serve.
    always_comb begin
        jitter_off = off_q;
        if (state == REACT && next_state == TRACK)
            jitter_off = {{28{lfsr_q[4]}}, lfsr_q[4:0]};
    end

    always_ff @(posedge clk) begin
        if (reset) off_q <= '0;
        else       off_q <= jitter_off;
    end
`else
    assign jitter_off = '0;
`endif

    // Drive decisions are made against the state being entered, so outputs follow with one cycle latency.
    always_comb begin
        aim    = {ball_y[31], ball_y} + jitter_off;
        target = Y_MID;
        if (next_state == TRACK) begin
            if (aim < 0)          target = '0;
            else if (aim > Y_MAX) target = Y_MAX;
            else                  target = aim;
        end
        err       = target - {paddle_position[31], paddle_position};
        want_up   = (next_state == TRACK || next_state == RECENTER) && (err > DB_POS);
        want_down = (next_state == TRACK || next_state == RECENTER) && (err < DB_NEG);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            up    <= 1'b0;
            down  <= 1'b0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
            // A reversal passes through one idle cycle so the tracker's accumulator clears.
            up    <= want_up && !down;
            down  <= want_down && !up;
        end
    end

    assign ai_state = state;

endmodule

// File: tb/tb_paddle_ai.sv
// Scoreboard bench for paddle_ai: directed scenarios then random play against a reference model.
module tb_paddle_ai;

    localparam int RT = 4;
    localparam int DB = 8;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               game_on = 1'b0;
    logic               ball_toward = 1'b0;
    logic signed [31:0] ball_y = 0;
    logic signed [31:0] paddle_position = 0;
    logic               up, down;
    logic [1:0]         ai_state;

    int n_vec  = 0;
    int n_fail = 0;

    logic [3:0] exp_q[$];

    // reference model state: 0 idle, 1 react, 2 track, 3 recenter
    int m_state = 0;
    int m_left  = 0;
    bit m_up    = 0;
    bit m_dn    = 0;

    paddle_ai #(.REACTION_TICKS(RT), .DEADBAND(DB)) dut (
        .clk             (clk),
        .reset           (reset),
        .game_on         (game_on),
        .ball_toward     (ball_toward),
        .ball_y          (ball_y),
        .paddle_position (paddle_position),
        .up              (up),
        .down            (down),
        .ai_state        (ai_state)
    );

    always #5 clk = ~clk;

    function automatic int clamp_y(input int y);
        if (y < 0)   return 0;
        if (y > 600) return 600;
        return y;
    endfunction

    // Behaviour after the coming clock edge, given the inputs held across it.
    task automatic model_step(input bit rst, input bit go, input bit tow, input int by, input int pp);
        longint err;
        int     tgt;
        bit     wu, wd;
        if (rst || !go) begin
            m_state = 0;
            m_left  = 0;
            m_up    = 0;
            m_dn    = 0;
        end else begin
            case (m_state)
                0: begin
                    if (tow) begin m_state = 1; m_left = RT; end
                    else m_state = 3;
                end
                1: begin
                    m_left = m_left - 1;
                    if (m_left == 0) m_state = 2;
                end
                2: if (!tow) m_state = 3;
                default: if (tow) begin m_state = 1; m_left = RT; end
            endcase
            wu = 0;
            wd = 0;
            if (m_state == 2 || m_state == 3) begin
                tgt = (m_state == 2) ? clamp_y(by) : 300;
                err = longint'(tgt) - longint'(pp);
                wu  = err > DB;
                wd  = err < -DB;
            end
            begin
                bit pu;
                pu   = m_up;
                m_up = wu && !m_dn;
                m_dn = wd && !pu;
            end
        end
        exp_q.push_back({2'(m_state), m_up, m_dn});
    endtask

    task automatic step(input bit rst, input bit go, input bit tow, input int by, input int pp);
        @(negedge clk);
        reset           = rst;
        game_on         = go;
        ball_toward     = tow;
        ball_y          = by;
        paddle_position = pp;
        model_step(rst, go, tow, by, pp);
    endtask

    task automatic step_n(input int n, input bit go, input bit tow, input int by, input int pp);
        for (int i = 0; i < n; i++) step(1'b0, go, tow, by, pp);
    endtask

    // Monitor: compares every cycle's outputs against the scoreboard.
    initial begin
        logic [3:0] e;
        logic [3:0] g;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = {ai_state, up, down};
                n_vec++;
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL cycle_out t=%0t got state=%0d up=%0b down=%0b want state=%0d up=%0b down=%0b",
                             $time, g[3:2], g[1], g[0], e[3:2], e[1], e[0]);
                end
            end
        end
    end

    initial begin
        int by, pp, tgt;
        bit go, tow, rst;

        step(1'b1, 1'b0, 1'b0, 0, 0);
        step(1'b1, 1'b1, 1'b1, 400, 300);

        // serve toward us: react, then track ball at 400
        step_n(8, 1'b1, 1'b1, 400, 300);
        step_n(3, 1'b1, 1'b1, 400, 392);
        step_n(3, 1'b1, 1'b1, 400, 300);
        // jump below while driving up: idle cycle, then down
        step_n(4, 1'b1, 1'b1, 100, 300);
        step_n(3, 1'b1, 1'b1, 900, 600);
        step_n(3, 1'b1, 1'b1, 900, 500);
        step_n(3, 1'b1, 1'b1, -50, 0);
        step_n(3, 1'b1, 1'b1, -50, 9);
        // ball leaves: recentre from 100
        step_n(3, 1'b1, 1'b0, 0, 100);
        step_n(2, 1'b1, 1'b0, 0, 291);
        step_n(2, 1'b1, 1'b0, 0, 292);
        step_n(2, 1'b1, 1'b0, 0, 308);
        step_n(2, 1'b1, 1'b0, 0, 309);
        // game_on dropped during track
        step_n(7, 1'b1, 1'b1, 500, 200);
        step_n(2, 1'b0, 1'b1, 500, 200);
        // reset pulsed mid-react
        step_n(3, 1'b1, 1'b1, 500, 200);
        step(1'b1, 1'b1, 1'b1, 500, 200);
        step_n(8, 1'b1, 1'b1, 500, 200);
        // extreme positions exercise the wide error path
        step_n(2, 1'b1, 1'b1, 32'sh7fffffff, 32'sh80000000);
        step_n(2, 1'b1, 1'b1, 32'sh80000000, 32'sh7fffffff);

        go  = 1;
        tow = 1;
        by  = 300;
        pp  = 300;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 59) == 0) go = ~go;
            if ($urandom_range(0, 19) == 0) tow = ~tow;
            if ($urandom_range(0, 3) == 0) by = $urandom_range(0, 900) - 150;
            tgt = tow ? clamp_y(by) : 300;
            case ($urandom_range(0, 3))
                0: pp = $urandom_range(0, 800) - 100;
                1: pp = tgt + $urandom_range(0, 2) + 7 - 2 * (($urandom_range(0, 1) == 0) ? 0 : (tgt > 0 ? 0 : 0)) ;
                2: pp = tgt - ($urandom_range(0, 2) + 7);
                default: pp = tgt + $urandom_range(0, 40) - 20;
            endcase
            step(rst, go, tow, by, pp);
        end

        step_n(2, 1'b0, 1'b0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/paddle_ai.md
PADDLE_AI -- requirements
Module: paddle_ai

Interface
REQ-001 SHALL have parameter: REACTION_TICKS, 1000, cycles between ball turning toward the paddle and tracking start (min 1).
REQ-002 SHALL have parameter: DEADBAND, 8, half-width in px of the no-drive window around the target.
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port: game_on  input  1  play enable.
REQ-006 SHALL have port: ball_toward  input  1  ball travelling toward this paddle.
REQ-007 SHALL have port: ball_y  input  32 signed  ball centre row.
REQ-008 SHALL have port: paddle_position  input  32 signed  current paddle centre row, fed back from the paddle tracker.
REQ-009 SHALL have ports: up, down  output  1 each  button commands to the paddle tracker; up increments position.
REQ-010 SHALL have port: ai_state  output  2  current FSM state, for debug.

Function
REQ-011 SHALL implement FSM states IDLE, REACT, TRACK and RECENTER.
REQ-012 IDLE: up=down=0; when game_on=1, SHALL go to REACT if ball_toward=1, else to RECENTER.
REQ-013 REACT: up=down=0; SHALL increment the reaction counter each cycle; at count REACTION_TICKS-1 SHALL go to TRACK and clear the counter.
REQ-014 TRACK: target SHALL equal ball_y clamped to 0..Y_RESOLUTION, re-evaluated every cycle; ball_toward=0 SHALL go to RECENTER.
REQ-015 RECENTER: target SHALL equal Y_RESOLUTION/2; ball_toward=1 SHALL go to REACT with the counter cleared.
REQ-016 Error err = target - paddle_position SHALL be computed 33-bit signed with no overflow.
REQ-017 In TRACK/RECENTER: err > DEADBAND SHALL request up; err < -DEADBAND SHALL request down; otherwise no request. |err| == DEADBAND SHALL be no request.
REQ-018 up/down SHALL be registered: one cycle latency from inputs to outputs.
REQ-019 up and down SHALL never be 1 in the same cycle.
REQ-020 A reversal (up to down or down to up) SHALL insert at least one cycle with both low, so the paddle tick accumulator clears.
REQ-021 game_on=0 in any state SHALL go to IDLE on the next edge, with up=down=0 from that edge on; the counter SHALL be cleared.
REQ-022 If ball_toward and game_on change in the same cycle, the game_on rule SHALL take priority.

Reset
REQ-023 On reset=1 at a clock edge: state=IDLE, up=0, down=0, counter=0, target=Y_RESOLUTION/2, ai_state=IDLE encoding.
REQ-024 Reset asserted mid-REACT or mid-TRACK SHALL abandon the operation with no residual drive on the following cycle.

Configuration
REQ-025 With PADDLE_AI_JITTER_EN defined, a 16-bit LFSR SHALL advance every cycle.
REQ-026 With PADDLE_AI_JITTER_EN defined, on each REACT-to-TRACK transition, LFSR bits [4:0] SHALL be sampled as a signed offset (-16..+15), held until the next REACT, and added to the target before clamping.
REQ-027 With PADDLE_AI_JITTER_EN undefined, the offset SHALL be 0 and no LFSR logic SHALL exist.
REQ-028 The LFSR SHALL reset to the nonzero seed 16'hACE1.

Structure
REQ-029 Shared package pong_pkg SHALL hold Y_RESOLUTION (600) and the ai_state_t enum; both the paddle tracker and paddle_ai SHALL import them.
REQ-030 The LFSR SHALL be sub-module lfsr16 (ports clk, reset, en, q[15:0]), instantiated only under PADDLE_AI_JITTER_EN.

Verification
REQ-031 Reset, then game_on=1, ball_toward=1, REACTION_TICKS=4 -> REACT for 4 cycles with up=down=0, then ai_state=TRACK.
REQ-032 TRACK, ball_y=400, paddle_position=300 -> up=1 one cycle later; paddle_position=392 -> up=0, down=0.
REQ-033 TRACK with up=1, ball_y jumps to 100 -> one cycle with up=down=0, then down=1.
REQ-034 ball_y=900 or ball_y=-50 -> target clamped to 600 or 0; paddle_position=600 with ball_y=900 -> no drive.
REQ-035 ball_toward=0 with paddle_position=100 -> RECENTER, up=1 until position >= 292.
REQ-036 game_on dropped during TRACK, or reset pulsed during REACT -> IDLE next cycle, outputs 0, counter 0.
